// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave: edge classification and synchroniser depth.
package spi_pkg;

  localparam int unsigned SPI_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    EDGE_NONE,
    EDGE_SAMPLE,
    EDGE_SHIFT
  } spi_edge_t;

  // Map a detected SCK rise/fall to sample or shift according to the SPI mode.
  function automatic spi_edge_t spi_classify(input logic cpol, input logic cpha,
                                             input logic rise, input logic fall);
    logic lead;
    logic trail;
    lead  = cpol ? fall : rise;
    trail = cpol ? rise : fall;
    if (cpha ? trail : lead) return EDGE_SAMPLE;
    if (cpha ? lead : trail) return EDGE_SHIFT;
    return EDGE_NONE;
  endfunction

endpackage

// File: rtl/spi_bus.sv
// SPIbus fabric interface: one master, NUM_SS slave select lines (active high).
interface SPIbus #(
  parameter int unsigned NUM_SS = 1
);
  logic              sck;
  logic              mosi;
  logic              miso;
  logic [NUM_SS-1:0] ss;

  modport Slave  (input sck, mosi, ss, output miso);
  modport Master (output sck, mosi, ss, input miso);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; pushes when full and pops when empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     Clk_i,
  input  logic                     Rst_ni,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     push,
  output logic [WIDTH-1:0]         rdata,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign level   = wptr - rptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge Clk_i) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/spi_slave_fifo.sv
// Full-duplex SPI slave, any CPOL/CPHA, with a transmit FIFO feeding MISO.
module spi_slave_fifo
  import spi_pkg::*;
#(
  parameter int unsigned ID       = 0,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TX_DEPTH = 4,
  parameter logic        CPOL     = 1'b0,
  parameter logic        CPHA     = 1'b0
) (
  input  logic                        Clk_i,
  input  logic                        Rst_ni,
  SPIbus.Slave                        Spis,
  input  logic [WIDTH-1:0]            tx_data_i,
  input  logic                        tx_valid_i,
  output logic                        tx_ready_o,
  output logic [$clog2(TX_DEPTH):0]   tx_level_o,
  output logic [WIDTH-1:0]            rx_data_o,
  output logic                        rx_valid_o,
  output logic                        tx_underrun_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [SPI_SYNC_STAGES-1:0] sck_sync;
  logic [SPI_SYNC_STAGES-1:0] mosi_sync;
  logic [SPI_SYNC_STAGES-1:0] ss_sync;
  logic                       sck_d;
  logic                       ss_d;
  logic                       sck_s;
  logic                       mosi_s;
  logic                       ss_s;
  logic                       sel_rise;
  logic                       sel_fall;
  logic                       active;
  spi_edge_t                  sck_edge;

  logic [CNT_W-1:0]           cnt;
  logic [WIDTH-1:0]           rx_sr;
  logic [WIDTH-1:0]           tx_sr;
  logic                       word_done;
  logic                       load;

  logic [WIDTH-1:0]           fifo_rdata;
  logic                       fifo_full;
  logic                       fifo_empty;

  // Two-stage synchronisers plus one delay stage for edge detection.
  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      sck_sync  <= {SPI_SYNC_STAGES{CPOL}};
      mosi_sync <= '0;
      ss_sync   <= '0;
      sck_d     <= CPOL;
      ss_d      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SPI_SYNC_STAGES-2:0], Spis.sck};
      mosi_sync <= {mosi_sync[SPI_SYNC_STAGES-2:0], Spis.mosi};
      ss_sync   <= {ss_sync[SPI_SYNC_STAGES-2:0], Spis.ss[ID]};
      sck_d     <= sck_s;
      ss_d      <= ss_s;
    end
  end

  assign sck_s    = sck_sync[SPI_SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SPI_SYNC_STAGES-1];
  assign ss_s     = ss_sync[SPI_SYNC_STAGES-1];
  assign sel_rise = ss_s && !ss_d;
  assign sel_fall = !ss_s && ss_d;
  assign active   = ss_s && ss_d;
  assign sck_edge = spi_classify(CPOL, CPHA, sck_s && !sck_d, !sck_s && sck_d);

  // Decide whether this cycle pops a new word into the transmit shifter.
  always_comb begin
    load = 1'b0;
    if (sel_rise) begin
      load = !CPHA;
    end else if (active && (sck_edge == EDGE_SHIFT)) begin
      load = CPHA ? (cnt == '0) : word_done;
    end
  end

  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      cnt           <= '0;
      rx_sr         <= '0;
      tx_sr         <= '0;
      word_done     <= 1'b0;
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      tx_underrun_o <= 1'b0;
    end else begin
      rx_valid_o    <= 1'b0;
      tx_underrun_o <= 1'b0;

      if (sel_rise || sel_fall) begin
        cnt       <= '0;
        rx_sr     <= '0;
        word_done <= 1'b0;
      end
      if (sel_fall) tx_sr <= '0;

      if (load) begin
        tx_sr         <= fifo_empty ? '0 : fifo_rdata;
        tx_underrun_o <= fifo_empty;
        word_done     <= 1'b0;
      end else if (active && (sck_edge == EDGE_SHIFT)) begin
        tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
      end

      if (active && (sck_edge == EDGE_SAMPLE)) begin
        rx_sr <= {rx_sr[WIDTH-2:0], mosi_s};
        if (cnt == CNT_W'(WIDTH-1)) begin
          cnt        <= '0;
          rx_data_o  <= {rx_sr[WIDTH-2:0], mosi_s};
          rx_valid_o <= 1'b1;
          word_done  <= !CPHA;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // MISO is released whenever the raw select is low so other slaves can drive the line.
  assign Spis.miso = Spis.ss[ID] ? tx_sr[WIDTH-1] : 1'bz;

  assign tx_ready_o = !fifo_full;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .Clk_i  (Clk_i),
    .Rst_ni (Rst_ni),
    .wdata  (tx_data_i),
    .push   (tx_valid_i),
    .rdata  (fifo_rdata),
    .pop    (load),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (tx_level_o)
  );

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Scoreboard bench: mode 0 and mode 3 slaves driven by one master, checked against a queue model.
module tb_spi_slave_fifo;

  localparam int H = 4;

  logic       clk;
  logic       rst_n;
  logic       sck0;
  logic       sck3;
  logic       mosi;
  logic       ss;
  logic [7:0] tx_data;
  logic       tx_valid0, tx_valid3;
  logic       ready0, ready3;
  logic [2:0] level0, level3;
  logic [7:0] rx_data0, rx_data3;
  logic       rx_valid0, rx_valid3;
  logic       und0, und3;

  SPIbus bus0 ();
  SPIbus bus3 ();

  assign bus0.sck  = sck0;
  assign bus0.mosi = mosi;
  assign bus0.ss   = ss;
  assign bus3.sck  = sck3;
  assign bus3.mosi = mosi;
  assign bus3.ss   = ss;

  spi_slave_fifo #(.ID(0), .WIDTH(8), .TX_DEPTH(4), .CPOL(1'b0), .CPHA(1'b0)) u_m0 (
    .Clk_i(clk), .Rst_ni(rst_n), .Spis(bus0),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid0), .tx_ready_o(ready0),
    .tx_level_o(level0), .rx_data_o(rx_data0), .rx_valid_o(rx_valid0),
    .tx_underrun_o(und0)
  );

  spi_slave_fifo #(.ID(0), .WIDTH(8), .TX_DEPTH(4), .CPOL(1'b1), .CPHA(1'b1)) u_m3 (
    .Clk_i(clk), .Rst_ni(rst_n), .Spis(bus3),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid3), .tx_ready_o(ready3),
    .tx_level_o(level3), .rx_data_o(rx_data3), .rx_valid_o(rx_valid3),
    .tx_underrun_o(und3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] fifo_m0 [$];
  logic [7:0] fifo_m3 [$];
  logic [7:0] exp_rx0 [$];
  logic [7:0] exp_rx3 [$];
  int und_exp0 = 0, und_exp3 = 0, und_seen0 = 0, und_seen3 = 0;
  logic rv0_d = 1'b0, rv3_d = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Receive monitor: every rx_valid pulse must match the oldest word the master sent.
  always @(negedge clk) begin
    if (!rst_n) begin
      rv0_d = 1'b0;
      rv3_d = 1'b0;
    end else begin
      if (rx_valid0) begin
        chk("rx0_pending", 32'(exp_rx0.size() > 0), 1);
        chk("rx0_pulse_width", 32'(rv0_d), 0);
        if (exp_rx0.size() > 0) chk("rx0_data", 32'(rx_data0), 32'(exp_rx0.pop_front()));
      end
      if (rx_valid3) begin
        chk("rx3_pending", 32'(exp_rx3.size() > 0), 1);
        chk("rx3_pulse_width", 32'(rv3_d), 0);
        if (exp_rx3.size() > 0) chk("rx3_data", 32'(rx_data3), 32'(exp_rx3.pop_front()));
      end
      if (und0) und_seen0++;
      if (und3) und_seen3++;
      rv0_d = rx_valid0;
      rv3_d = rx_valid3;
    end
  end

  task automatic pop_m(input int d, output logic [7:0] w);
    if (d == 0) begin
      if (fifo_m0.size() == 0) begin w = '0; und_exp0++; end
      else w = fifo_m0.pop_front();
    end else begin
      if (fifo_m3.size() == 0) begin w = '0; und_exp3++; end
      else w = fifo_m3.pop_front();
    end
  endtask

  task automatic push(input int d, input logic [7:0] v);
    logic acc;
    acc = (d == 0) ? (fifo_m0.size() < 4) : (fifo_m3.size() < 4);
    tx_data = v;
    if (d == 0) begin
      chk("ready0", 32'(ready0), 32'(acc));
      tx_valid0 = 1'b1;
    end else begin
      chk("ready3", 32'(ready3), 32'(acc));
      tx_valid3 = 1'b1;
    end
    @(negedge clk);
    tx_valid0 = 1'b0;
    tx_valid3 = 1'b0;
    if (d == 0) begin
      if (acc) fifo_m0.push_back(v);
      chk("level0_push", 32'(level0), 32'(fifo_m0.size()));
    end else begin
      if (acc) fifo_m3.push_back(v);
      chk("level3_push", 32'(level3), 32'(fifo_m3.size()));
    end
  endtask

  // One selection: nwords full words, then optionally a partial word of abort_bits bits.
  task automatic xfer(input logic [7:0] rxw [4], input int nwords, input int abort_bits);
    logic [7:0] exp0 [4];
    logic [7:0] exp3 [4];
    logic [7:0] cur, dummy, got0, got3;
    int nw, nb;
    nw = nwords + ((abort_bits > 0) ? 1 : 0);
    pop_m(0, cur);
    for (int w = 0; w < nwords; w++) begin
      exp0[w] = cur;
      pop_m(0, cur);
      pop_m(3, exp3[w]);
    end
    if (abort_bits > 0) pop_m(3, dummy);

    ss = 1'b1;
    repeat (6) @(negedge clk);
    for (int w = 0; w < nw; w++) begin
      nb = (w < nwords) ? 8 : abort_bits;
      if (w < nwords) begin
        exp_rx0.push_back(rxw[w]);
        exp_rx3.push_back(rxw[w]);
      end
      got0 = '0;
      got3 = '0;
      for (int b = 0; b < nb; b++) begin
        sck0 = 1'b0;
        sck3 = 1'b0;
        mosi = rxw[w][7-b];
        repeat (H) @(negedge clk);
        got0[7-b] = bus0.miso;
        got3[7-b] = bus3.miso;
        sck0 = 1'b1;
        sck3 = 1'b1;
        repeat (H) @(negedge clk);
      end
      if (w < nwords) begin
        chk("miso0_word", 32'(got0), 32'(exp0[w]));
        chk("miso3_word", 32'(got3), 32'(exp3[w]));
      end
    end
    sck0 = 1'b0;
    repeat (H) @(negedge clk);
    ss = 1'b0;
    repeat (6) @(negedge clk);
    chk("rx0_all_received", 32'(exp_rx0.size()), 0);
    chk("rx3_all_received", 32'(exp_rx3.size()), 0);
    chk("underrun0_count", 32'(und_seen0), 32'(und_exp0));
    chk("underrun3_count", 32'(und_seen3), 32'(und_exp3));
    chk("level0_after", 32'(level0), 32'(fifo_m0.size()));
    chk("level3_after", 32'(level3), 32'(fifo_m3.size()));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready0"}, 32'(ready0), 1);
    chk({tag, "_ready3"}, 32'(ready3), 1);
    chk({tag, "_level0"}, 32'(level0), 0);
    chk({tag, "_level3"}, 32'(level3), 0);
    chk({tag, "_rxdata0"}, 32'(rx_data0), 0);
    chk({tag, "_rxdata3"}, 32'(rx_data3), 0);
    chk({tag, "_rxvalid"}, 32'({rx_valid0, rx_valid3}), 0);
    chk({tag, "_underrun"}, 32'({und0, und3}), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rw [4];
    rst_n = 1'b0; ss = 1'b0; sck0 = 1'b0; sck3 = 1'b1; mosi = 1'b0;
    tx_data = '0; tx_valid0 = 1'b0; tx_valid3 = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    rw = '{8'hA5, 8'h3C, 8'h00, 8'h00};
    xfer(rw, 2, 0);

    push(0, 8'h81); push(0, 8'h7E);
    push(3, 8'h81); push(3, 8'h7E);
    chk("duplex_level0", 32'(level0), 2);
    chk("duplex_level3", 32'(level3), 2);
    rw = '{8'h5A, 8'hC3, 8'h00, 8'h00};
    xfer(rw, 2, 0);

    rw = '{8'h96, 8'h00, 8'h00, 8'h00};
    xfer(rw, 1, 0);

    for (int i = 0; i < 5; i++) begin
      push(0, 8'(8'h10 + i));
      push(3, 8'(8'h20 + i));
    end
    chk("full_level0", 32'(level0), 4);
    chk("full_level3", 32'(level3), 4);
    chk("full_ready", 32'({ready0, ready3}), 0);

    rw = '{8'hF0, 8'h00, 8'h00, 8'h00};
    xfer(rw, 0, 5);
    rw = '{8'h69, 8'h00, 8'h00, 8'h00};
    xfer(rw, 1, 0);

    push(0, 8'hAA); push(0, 8'hBB);
    push(3, 8'hCC); push(3, 8'hDD);
    ss = 1'b1;
    repeat (6) @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      sck0 = 1'b0; sck3 = 1'b0; mosi = b[0];
      repeat (H) @(negedge clk);
      sck0 = 1'b1; sck3 = 1'b1;
      repeat (H) @(negedge clk);
    end
    sck0 = 1'b0; sck3 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    ss = 1'b0; sck3 = 1'b1;
    fifo_m0.delete(); fifo_m3.delete();
    repeat (3) @(negedge clk);
    chk_reset_vals("midreset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("postreset");
    ss = 1'b1;
    und_exp0++;
    repeat (6) @(negedge clk);
    chk("postreset_miso0", 32'(bus0.miso), 0);
    chk("postreset_miso3", 32'(bus3.miso), 0);
    ss = 1'b0;
    repeat (6) @(negedge clk);
    chk("postreset_und0", 32'(und_seen0), 32'(und_exp0));
    chk("postreset_und3", 32'(und_seen3), 32'(und_exp3));

    for (int it = 0; it < 16; it++) begin
      int np0, np3, nwords, abits;
      np0 = int'($urandom_range(0, 4));
      np3 = int'($urandom_range(0, 4));
      for (int i = 0; i < np0; i++) push(0, 8'($urandom));
      for (int i = 0; i < np3; i++) push(3, 8'($urandom));
      for (int i = 0; i < 4; i++) rw[i] = 8'($urandom);
      nwords = int'($urandom_range(1, 3));
      abits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      xfer(rw, nwords, abits);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
